// File: rtl/ahb_bram_pkg.sv
// Shared definitions for the AHB-Lite block-RAM controller:
//   - HTRANS / HSIZE encodings
//   - controller FSM state type
//   - byte-lane decode helper returning {bad, mask}
package ahb_bram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  typedef struct packed {
    logic       bad;
    logic [3:0] mask;
  } lane_t;

  // Misaligned halfwords/words and sizes wider than a word are bad.
  function automatic lane_t lane_decode(input logic [1:0] lo, input logic [2:0] size);
    lane_t r;
    r.bad  = 1'b0;
    r.mask = 4'h0;
    case (size)
      HSIZE_BYTE: r.mask = 4'b0001 << lo;
      HSIZE_HALF: begin
        if (lo == 2'd0)      r.mask = 4'h3;
        else if (lo == 2'd2) r.mask = 4'hC;
        else                 r.bad  = 1'b1;
      end
      HSIZE_WORD: begin
        if (lo == 2'd0) r.mask = 4'hF;
        else            r.bad  = 1'b1;
      end
      default: r.bad = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ahb_bram_lane_dec.sv
// Byte-lane decoder.
//   addr_lo : HADDR[1:0]
//   size    : HSIZE
//   mask    : byte enables of the transfer (0 when bad)
//   bad     : misaligned or unsupported size
module ahb_bram_lane_dec
  import ahb_bram_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [2:0] size,
  output logic [3:0] mask,
  output logic       bad
);

  lane_t dec;

  assign dec  = lane_decode(addr_lo, size);
  assign mask = dec.mask;
  assign bad  = dec.bad;

endmodule

// File: rtl/ahblite_bram_ctrl.sv
// AHB-Lite slave in front of a synchronous block RAM with separate read and
// write address ports.
//   HCLK/HRESETn          : clock, async active-low reset
//   HSEL..HREADY          : AHB-Lite slave inputs (HPROT ignored)
//   HREADYOUT/HRESP       : registered slave response
//   HRDATA                : BRAM data, merged with forwarded write bytes
//   BRAM_RDADDR/RDEN      : read port, driven in the address phase
//   BRAM_WRADDR/WRITE     : write port, driven in the write data phase
//   BRAM_WDATA            : HWDATA passthrough
//   BRAM_RDATA            : BRAM read output (RD_LATENCY cycles after RDEN)
module ahblite_bram_ctrl
  import ahb_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int RD_LATENCY = 1,
  parameter int WP_WORDS   = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [3:0]            HPROT,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
  output logic                  BRAM_RDEN,
  output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
  output logic [31:0]           BRAM_WDATA,
  output logic [3:0]            BRAM_WRITE,
  input  logic [31:0]           BRAM_RDATA
);

  localparam logic [ADDR_WIDTH:0] WP_LIM = (ADDR_WIDTH+1)'(WP_WORDS);

  state_t                  state;
  logic                    accept, bad, bad_align, wp_hit, wr_go, rd_go;
  logic [3:0]              mask;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [3:0]              wr_be;
  logic [3:0]              fwd_mask;
  logic [31:0]             fwd_data;
  logic                    unused_bits;

  assign unused_bits = ^{HPROT, HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  ahb_bram_lane_dec u_dec (
    .addr_lo (HADDR[1:0]),
    .size    (HSIZE),
    .mask    (mask),
    .bad     (bad_align)
  );

  assign idx    = HADDR[ADDR_WIDTH+1:2];
  assign accept = HSEL & HTRANS[1] & HREADY;
  assign wp_hit = HWRITE & ({1'b0, idx} < WP_LIM);
  assign bad    = bad_align | wp_hit;
  assign wr_go  = accept & HWRITE & ~bad;
  assign rd_go  = accept & ~HWRITE & ~bad;

  assign BRAM_RDADDR = idx;
  assign BRAM_RDEN   = rd_go;
  assign BRAM_WDATA  = HWDATA;
  assign BRAM_WRITE  = wr_be;

  // Write port: the address phase is registered, the BRAM strobe fires in the
  // data phase when HWDATA is valid. wr_be is zero whenever no good write was
  // accepted in the previous cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_be       <= 4'h0;
      BRAM_WRADDR <= '0;
    end else begin
      wr_be <= wr_go ? mask : 4'h0;
      if (wr_go) BRAM_WRADDR <= idx;
    end
  end

  // A read accepted during the data phase of a write to the same word sees the
  // pre-write BRAM contents, so the written bytes are captured here and merged
  // when the read data returns. Held through RD_WAIT so the merge lines up
  // with the delayed data.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fwd_mask <= 4'h0;
      fwd_data <= 32'h0;
    end else if (state != ST_RD_WAIT) begin
      if (rd_go && (wr_be != 4'h0) && (BRAM_WRADDR == idx)) begin
        fwd_mask <= wr_be;
        fwd_data <= HWDATA;
      end else begin
        fwd_mask <= 4'h0;
      end
    end
  end

  always_comb begin
    HRDATA = BRAM_RDATA;
    for (int i = 0; i < 4; i++)
      if (fwd_mask[i]) HRDATA[8*i +: 8] = fwd_data[8*i +: 8];
  end

  // Response FSM. ERR2 behaves like IDLE for a new transfer since HREADYOUT
  // is high there and the next address phase is sampled normally.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ERR2: begin
          if (accept && bad) begin
            state     <= ST_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b1;
          end else if (rd_go && (RD_LATENCY == 2)) begin
            state     <= ST_RD_WAIT;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b0;
          end else begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
        ST_RD_WAIT: begin
          state     <= ST_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahblite_bram_ctrl.sv
// Scoreboard bench: dut0 has RD_LATENCY=1, WP_WORDS=4; dut1 has RD_LATENCY=2,
// WP_WORDS=0. One DUT is driven at a time; stimulus pushes the expected data
// phase result, the monitor pops and compares when the data phase completes.
module tb_ahblite_bram_ctrl;
  import ahb_bram_pkg::*;

  localparam int AW = 10;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    logic [3:0]  be;
    logic [AW-1:0] wa;
    bit          resp;
    int          waits;
    int          dut;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  hsel = 2'b00;
  logic [31:0] haddr = 32'h0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic [2:0]  hsize = HSIZE_WORD;
  logic [3:0]  hprot = 4'h0;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = 32'h0;

  logic [1:0]    ro, rsp, rden;
  logic [31:0]   hrdata [2];
  logic [AW-1:0] rdaddr [2];
  logic [AW-1:0] wraddr [2];
  logic [31:0]   wdata  [2];
  logic [3:0]    bw     [2];
  logic [31:0]   brdata [2];

  ahblite_bram_ctrl #(.ADDR_WIDTH(AW), .RD_LATENCY(1), .WP_WORDS(4)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HPROT(hprot), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(ro[0]),
    .HREADYOUT(ro[0]), .HRDATA(hrdata[0]), .HRESP(rsp[0]), .BRAM_RDADDR(rdaddr[0]),
    .BRAM_RDEN(rden[0]), .BRAM_WRADDR(wraddr[0]), .BRAM_WDATA(wdata[0]),
    .BRAM_WRITE(bw[0]), .BRAM_RDATA(brdata[0])
  );

  ahblite_bram_ctrl #(.ADDR_WIDTH(AW), .RD_LATENCY(2), .WP_WORDS(0)) dut1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HPROT(hprot), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(ro[1]),
    .HREADYOUT(ro[1]), .HRDATA(hrdata[1]), .HRESP(rsp[1]), .BRAM_RDADDR(rdaddr[1]),
    .BRAM_RDEN(rden[1]), .BRAM_WRADDR(wraddr[1]), .BRAM_WDATA(wdata[1]),
    .BRAM_WRITE(bw[1]), .BRAM_RDATA(brdata[1])
  );

  // Behavioural read-first BRAMs, latency 1 for dut0 and 2 for dut1.
  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];
  logic [31:0] p1_0, p1_1, p2_1;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bw[0][i]) mem0[wraddr[0]][8*i +: 8] <= wdata[0][8*i +: 8];
      if (bw[1][i]) mem1[wraddr[1]][8*i +: 8] <= wdata[1][8*i +: 8];
    end
    if (rden[0]) p1_0 <= mem0[rdaddr[0]];
    if (rden[1]) p1_1 <= mem1[rdaddr[1]];
    p2_1 <= p1_1;
  end

  assign brdata[0] = p1_0;
  assign brdata[1] = p2_1;

  exp_t sb[$];
  int   cur = 0;
  bit   done = 1'b0;
  logic [31:0] pend = 32'h0;

  function automatic exp_t mk(bit rd, logic [31:0] data, logic [3:0] be,
                              logic [AW-1:0] wa, bit resp, int waits);
    exp_t e;
    e.rd = rd; e.data = data; e.be = be; e.wa = wa;
    e.resp = resp; e.waits = waits; e.dut = cur;
    return e;
  endfunction

  task automatic wait_ready();
    logic r;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      r = ro[cur];
      @(posedge clk);
      #2;
      if (r) break;
      if (i > 20) begin
        $display("FAIL hready_timeout dut%0d: HREADYOUT stayed 0, want 1", cur);
        $fatal(1);
      end
    end
  endtask

  task automatic issue(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input exp_t e);
    hsel = 2'b00;
    hsel[cur] = 1'b1;
    htrans = HTRANS_NONSEQ;
    haddr = a;
    hwrite = wr;
    hsize = sz;
    hwdata = pend;
    sb.push_back(e);
    wait_ready();
    pend = wd;
  endtask

  task automatic idle();
    hsel = 2'b00;
    htrans = HTRANS_IDLE;
    hwdata = pend;
    wait_ready();
  endtask

  // Stimulus
  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // dut0: RD_LATENCY=1, words 0..3 write-protected
    cur = 0;
    issue(1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, mk(0, 0, 4'hF, 4, 0, 0));
    idle();
    issue(0, 32'h10, HSIZE_WORD, 0, mk(1, 32'hDEADBEEF, 0, 0, 0, 0));
    issue(1, 32'h10, HSIZE_WORD, 32'h11223344, mk(0, 0, 4'hF, 4, 0, 0));
    idle();
    issue(1, 32'h13, HSIZE_BYTE, 32'hAA55AA55, mk(0, 0, 4'h8, 4, 0, 0));
    issue(0, 32'h10, HSIZE_WORD, 0, mk(1, 32'hAA223344, 0, 0, 0, 0));
    idle();
    issue(0, 32'h10, HSIZE_WORD, 0, mk(1, 32'hAA223344, 0, 0, 0, 0));
    issue(1, 32'h0C, HSIZE_HALF, 32'h0000BEEF, mk(0, 0, 4'h0, 0, 1, 1));
    issue(1, 32'h10, HSIZE_HALF, 32'h0000BEEF, mk(0, 0, 4'h3, 4, 0, 0));
    issue(0, 32'h10, HSIZE_WORD, 0, mk(1, 32'hAA22BEEF, 0, 0, 0, 0));
    issue(0, 32'h11, HSIZE_WORD, 0, mk(0, 0, 4'h0, 0, 1, 1));
    issue(0, 32'h10, HSIZE_WORD, 0, mk(1, 32'hAA22BEEF, 0, 0, 0, 0));
    idle();
    idle();

    // dut1: RD_LATENCY=2, no protection
    cur = 1;
    issue(1, 32'h10, HSIZE_WORD, 32'h11223344, mk(0, 0, 4'hF, 4, 0, 0));
    idle();
    issue(1, 32'h13, HSIZE_BYTE, 32'hAA55AA55, mk(0, 0, 4'h8, 4, 0, 0));
    issue(0, 32'h10, HSIZE_WORD, 0, mk(1, 32'hAA223344, 0, 0, 0, 1));
    idle();
    issue(1, 32'h00, HSIZE_WORD, 32'h01020304, mk(0, 0, 4'hF, 0, 0, 0));
    issue(1, 32'h04, HSIZE_WORD, 32'h05060708, mk(0, 0, 4'hF, 1, 0, 0));
    issue(1, 32'h08, HSIZE_WORD, 32'h090A0B0C, mk(0, 0, 4'hF, 2, 0, 0));
    idle();
    issue(0, 32'h00, HSIZE_WORD, 0, mk(1, 32'h01020304, 0, 0, 0, 1));
    issue(0, 32'h04, HSIZE_WORD, 0, mk(1, 32'h05060708, 0, 0, 0, 1));
    issue(0, 32'h08, HSIZE_WORD, 0, mk(1, 32'h090A0B0C, 0, 0, 0, 1));
    idle();
    issue(1, 32'h02, HSIZE_WORD, 32'h12345678, mk(0, 0, 4'h0, 0, 1, 1));
    issue(1, 32'h02, HSIZE_HALF, 32'hBEEF0000, mk(0, 0, 4'hC, 0, 0, 0));
    issue(0, 32'h00, HSIZE_WORD, 0, mk(1, 32'hBEEF0304, 0, 0, 0, 1));
    idle();

    // reset while in RD_WAIT: the pending read is dropped
    issue(0, 32'h04, HSIZE_WORD, 0, mk(1, 32'h05060708, 0, 0, 0, 1));
    hsel = 2'b00;
    htrans = HTRANS_IDLE;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    issue(0, 32'h00, HSIZE_WORD, 0, mk(1, 32'hBEEF0304, 0, 0, 0, 1));
    idle();
    idle();
    done = 1'b1;
  end

  // Monitor / scoreboard
  int checks = 0;
  int errors = 0;

  initial begin
    bit   dph [2];
    int   wcnt [2];
    int   cyc;
    exp_t e;
    logic [3:0] want_be;
    dph[0] = 0; dph[1] = 0; wcnt[0] = 0; wcnt[1] = 0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          checks++;
          if (ro[d] !== 1'b1 || rsp[d] !== 1'b0 || bw[d] !== 4'h0 || rden[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state dut%0d: rdy=%b resp=%b we=%h rden=%b, want 1 0 0 0",
                     d, ro[d], rsp[d], bw[d], rden[d]);
          end
          dph[d] = 0;
          wcnt[d] = 0;
        end else begin
          if (dph[d]) begin
            if (sb.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_dphase dut%0d: no expected entry", d);
              dph[d] = 0;
            end else begin
              e = sb[0];
              checks++;
              if (rsp[d] !== e.resp || e.dut != d) begin
                errors++;
                $display("FAIL hresp dut%0d: got %b, want %b (entry dut%0d)", d, rsp[d], e.resp, e.dut);
              end
              want_be = (wcnt[d] == 0) ? e.be : 4'h0;
              checks++;
              if (bw[d] !== want_be) begin
                errors++;
                $display("FAIL bram_write dut%0d: got %h, want %h", d, bw[d], want_be);
              end
              if (wcnt[d] == 0 && e.be != 4'h0) begin
                checks++;
                if (wraddr[d] !== e.wa) begin
                  errors++;
                  $display("FAIL bram_wraddr dut%0d: got %h, want %h", d, wraddr[d], e.wa);
                end
              end
              if (ro[d]) begin
                checks++;
                if (wcnt[d] != e.waits) begin
                  errors++;
                  $display("FAIL wait_states dut%0d: got %0d, want %0d", d, wcnt[d], e.waits);
                end
                if (e.rd) begin
                  checks++;
                  if (hrdata[d] !== e.data) begin
                    errors++;
                    $display("FAIL hrdata dut%0d: got %h, want %h", d, hrdata[d], e.data);
                  end
                end
                void'(sb.pop_front());
                wcnt[d] = 0;
              end else begin
                wcnt[d]++;
                if (wcnt[d] > 4) begin
                  checks++; errors++;
                  $display("FAIL stall_timeout dut%0d: %0d wait states, want <= %0d", d, wcnt[d], e.waits);
                  void'(sb.pop_front());
                  wcnt[d] = 0;
                  dph[d] = 0;
                end
              end
            end
          end
          if (ro[d]) dph[d] = hsel[d] & htrans[1];
        end
      end
      if (!rst_n) sb.delete();
      if (done || cyc > 5000) begin
        checks++;
        if (cyc > 5000) begin
          errors++;
          $display("FAIL global_timeout: cycle %0d, want stimulus done", cyc);
        end else if (sb.size() != 0) begin
          errors++;
          $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

endmodule
